gobou_ctrl_core: RTL and testbench

GOBOU_CTRL_CORE -- requirements
Module: gobou_ctrl_core

---
 rtl/gobou_ctrl_core_pkg.sv | 34 +++
 rtl/gobou_ctrl_core_if.sv | 13 +
 rtl/gobou_ctrl_core_loop.sv | 81 ++++++++
 rtl/gobou_ctrl_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_gobou_ctrl_core.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/gobou_ctrl_core_pkg.sv
// gobou_ctrl_core_pkg
// Shared definitions for the GOBOU layer controller:
//   - default widths (IWIDTH / IMGSIZE / NETSIZE)
//   - FSM state enum
//   - ctrl_reg_t: registered start/valid/stop triple driven onto ctrl_bus
//   - saturating 32-bit increment helper for the busy-cycle counter
package gobou_ctrl_core_pkg;

    localparam int IWIDTH_DEF  = 10;
    localparam int IMGSIZE_DEF = 12;
    localparam int NETSIZE_DEF = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/gobou_ctrl_core_if.sv
// ctrl_bus
// Start/valid/stop sideband that travels alongside the data stream
// through the bias/ReLU pipeline.
//   master: drives start, valid, stop
//   slave : receives start, valid, stop
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface

// File: rtl/gobou_ctrl_core_loop.sv
// gobou_ctrl_loop
// Nested i (inner, 0..N-1) / o (outer, 0..M-1) element counter.
// Ports:
//   clk, xrst      : clock, synchronous active-low reset
//   clr_i          : load both counters with 0 (new layer)
//   step_i         : advance one element, i wraps into o, o wraps to 0
//   n_i, m_i       : sizes in force this cycle (for current last flags)
//   n_nxt_i,m_nxt_i: sizes in force next cycle (for next-value flags)
//   i_nxt_o,o_nxt_o: counter values after this edge
//   last_i_o/last_o_o         : current i==N-1 / o==M-1
//   last_i_nxt_o/last_o_nxt_o : same flags evaluated on the next values
// The next-value outputs let the parent register its outputs in the same
// cycle the counters update, so outputs stay aligned with the counters.
module gobou_ctrl_loop #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic         clr_i,
    input  logic         step_i,
    input  logic [W-1:0] n_i,
    input  logic [W-1:0] m_i,
    input  logic [W-1:0] n_nxt_i,
    input  logic [W-1:0] m_nxt_i,
    output logic [W-1:0] i_nxt_o,
    output logic [W-1:0] o_nxt_o,
    output logic         last_i_o,
    output logic         last_o_o,
    output logic         last_i_nxt_o,
    output logic         last_o_nxt_o
);

    logic [W-1:0] i_q;
    logic [W-1:0] o_q;
    logic [W-1:0] i_d;
    logic [W-1:0] o_d;

    assign last_i_o     = (i_q == (n_i - W'(1'b1)));
    assign last_o_o     = (o_q == (m_i - W'(1'b1)));
    assign last_i_nxt_o = (i_d == (n_nxt_i - W'(1'b1)));
    assign last_o_nxt_o = (o_d == (m_nxt_i - W'(1'b1)));
    assign i_nxt_o      = i_d;
    assign o_nxt_o      = o_d;

    // Next counter values: clear, step with wrap, or hold.
    always_comb begin
        i_d = i_q;
        o_d = o_q;
        if (clr_i) begin
            i_d = '0;
            o_d = '0;
        end else if (step_i) begin
            if (last_i_o) begin
                i_d = '0;
                if (last_o_o) begin
                    o_d = '0;
                end else begin
                    o_d = o_q + W'(1'b1);
                end
            end else begin
                i_d = i_q + W'(1'b1);
                o_d = o_q;
            end
        end else begin
            i_d = i_q;
            o_d = o_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            i_q <= '0;
            o_q <= '0;
        end else begin
            i_q <= i_d;
            o_q <= o_d;
        end
    end

endmodule

// File: rtl/gobou_ctrl_core.sv
// gobou_ctrl_core
// Layer sequencer for a fully-connected layer: walks N inputs x M neurons,
// addressing the input buffer and weight memory, driving the accumulator
// and the start/valid/stop sideband, then waits for the pipeline tail.
// Optional feature macro: GOBOU_PERF_EN (busy-cycle counter).
// Ports:
//   clk, xrst            : clock, synchronous active-low reset
//   req                  : layer start request (accepted only in idle, sizes != 0)
//   in_size, out_size    : N and M
//   net_offset           : first weight address
//   ack                  : 1 while idle
//   mem_in_addr          : input element index i
//   mem_net_addr         : net_offset + o*N + i (mod 2^NETSIZE)
//   acc_clr, acc_en      : accumulator clear (i==0) / enable
//   out_ctrl             : start/valid/stop towards bias/ReLU pipeline
//   done_ctrl            : start/valid/stop back from the pipeline tail
//   out_we, out_addr     : output buffer write strobe / address
//   busy_cycles          : cycles spent in S_CALC or S_DRAIN (0 without macro)
// All outputs are registers loaded from next-state values.
module gobou_ctrl_core
    import gobou_ctrl_core_pkg::*;
#(
    parameter int IWIDTH  = IWIDTH_DEF,
    parameter int IMGSIZE = IMGSIZE_DEF,
    parameter int NETSIZE = NETSIZE_DEF
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req,
    input  logic [IWIDTH-1:0]  in_size,
    input  logic [IWIDTH-1:0]  out_size,
    input  logic [NETSIZE-1:0] net_offset,
    output logic               ack,
    output logic [IMGSIZE-1:0] mem_in_addr,
    output logic [NETSIZE-1:0] mem_net_addr,
    output logic               acc_clr,
    output logic               acc_en,
    ctrl_bus.master            out_ctrl,
    ctrl_bus.slave             done_ctrl,
    output logic               out_we,
    output logic [IMGSIZE-1:0] out_addr,
    output logic [31:0]        busy_cycles
);

    state_t             state_q;
    state_t             state_d;
    logic               accept_s;
    logic               step_s;

    logic [IWIDTH-1:0]  n_q;
    logic [IWIDTH-1:0]  n_d;
    logic [IWIDTH-1:0]  m_q;
    logic [IWIDTH-1:0]  m_d;
    logic [NETSIZE-1:0] netptr_q;
    logic [NETSIZE-1:0] netptr_d;

    logic [IWIDTH-1:0]  i_nxt_s;
    logic [IWIDTH-1:0]  o_nxt_s;
    logic               last_i_s;
    logic               last_o_s;
    logic               last_i_nxt_s;
    logic               last_o_nxt_s;

    logic               ack_q;
    logic               ack_d;
    logic [IMGSIZE-1:0] mem_in_addr_q;
    logic [IMGSIZE-1:0] mem_in_addr_d;
    logic [NETSIZE-1:0] mem_net_addr_q;
    logic [NETSIZE-1:0] mem_net_addr_d;
    logic               acc_clr_q;
    logic               acc_clr_d;
    logic               acc_en_q;
    logic               acc_en_d;
    ctrl_reg_t          ctrl_q;
    ctrl_reg_t          ctrl_d;
    logic               out_we_q;
    logic [IMGSIZE-1:0] out_addr_q;
    logic [IMGSIZE-1:0] out_addr_d;
    logic               calc_nxt_s;

    // The returning start flag carries no information for this block.
    logic               unused_done_start_s;
    assign unused_done_start_s = done_ctrl.start;

    gobou_ctrl_loop #(
        .W (IWIDTH)
    ) u_loop (
        .clk          (clk),
        .xrst         (xrst),
        .clr_i        (accept_s),
        .step_i       (step_s),
        .n_i          (n_q),
        .m_i          (m_q),
        .n_nxt_i      (n_d),
        .m_nxt_i      (m_d),
        .i_nxt_o      (i_nxt_s),
        .o_nxt_o      (o_nxt_s),
        .last_i_o     (last_i_s),
        .last_o_o     (last_o_s),
        .last_i_nxt_o (last_i_nxt_s),
        .last_o_nxt_o (last_o_nxt_s)
    );

    // FSM next state, request acceptance and counter stepping.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        step_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && (in_size != '0) && (out_size != '0)) begin
                    accept_s = 1'b1;
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                step_s = 1'b1;
                // done_ctrl.stop is deliberately not looked at here.
                if (last_i_s && last_o_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DRAIN: begin
                if (done_ctrl.stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latched layer parameters, weight pointer and output-side next values.
    always_comb begin
        n_d        = n_q;
        m_d        = m_q;
        netptr_d   = netptr_q;
        out_addr_d = out_addr_q;
        if (accept_s) begin
            n_d        = in_size;
            m_d        = out_size;
            netptr_d   = net_offset;
            out_addr_d = '0;
        end else begin
            n_d = n_q;
            m_d = m_q;
            // Weight address is o*N+i, which advances by exactly one per element.
            if (state_q == S_CALC) begin
                netptr_d = netptr_q + NETSIZE'(1'b1);
            end else begin
                netptr_d = netptr_q;
            end
            if (out_we_q) begin
                out_addr_d = out_addr_q + IMGSIZE'(1'b1);
            end else begin
                out_addr_d = out_addr_q;
            end
        end

        calc_nxt_s = (state_d == S_CALC);
        ack_d      = (state_d == S_IDLE);
        if (calc_nxt_s) begin
            mem_in_addr_d  = IMGSIZE'(i_nxt_s);
            mem_net_addr_d = netptr_d;
            acc_en_d       = 1'b1;
            acc_clr_d      = (i_nxt_s == '0);
            ctrl_d.start   = (i_nxt_s == '0) && (o_nxt_s == '0);
            ctrl_d.valid   = last_i_nxt_s;
            ctrl_d.stop    = last_i_nxt_s && last_o_nxt_s;
        end else begin
            mem_in_addr_d  = '0;
            mem_net_addr_d = '0;
            acc_en_d       = 1'b0;
            acc_clr_d      = 1'b0;
            ctrl_d         = '0;
        end
    end

    // State, latched parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            m_q            <= '0;
            netptr_q       <= '0;
            ack_q          <= 1'b1;
            mem_in_addr_q  <= '0;
            mem_net_addr_q <= '0;
            acc_clr_q      <= 1'b0;
            acc_en_q       <= 1'b0;
            ctrl_q         <= '0;
            out_we_q       <= 1'b0;
            out_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            m_q            <= m_d;
            netptr_q       <= netptr_d;
            ack_q          <= ack_d;
            mem_in_addr_q  <= mem_in_addr_d;
            mem_net_addr_q <= mem_net_addr_d;
            acc_clr_q      <= acc_clr_d;
            acc_en_q       <= acc_en_d;
            ctrl_q         <= ctrl_d;
            out_we_q       <= done_ctrl.valid;
            out_addr_q     <= out_addr_d;
        end
    end

`ifdef GOBOU_PERF_EN
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Busy counter: clear on accept, count while not idle, saturate.
    always_comb begin
        if (accept_s) begin
            busy_d = 32'd0;
        end else if (state_q != S_IDLE) begin
            busy_d = sat_inc32(busy_q);
        end else begin
            busy_d = busy_q;
        end
    end

    // Busy counter register.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = 32'd0;
`endif

    assign ack            = ack_q;
    assign mem_in_addr    = mem_in_addr_q;
    assign mem_net_addr   = mem_net_addr_q;
    assign acc_clr        = acc_clr_q;
    assign acc_en         = acc_en_q;
    assign out_ctrl.start = ctrl_q.start;
    assign out_ctrl.valid = ctrl_q.valid;
    assign out_ctrl.stop  = ctrl_q.stop;
    assign out_we         = out_we_q;
    assign out_addr       = out_addr_q;

endmodule

// File: tb/tb_gobou_ctrl_core.sv
// Directed-vector bench for gobou_ctrl_core (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_gobou_ctrl_core;

    logic        clk = 1'b0;
    logic        xrst;
    logic        req;
    logic [9:0]  in_size;
    logic [9:0]  out_size;
    logic [13:0] net_offset;
    logic        ack;
    logic [11:0] mem_in_addr;
    logic [13:0] mem_net_addr;
    logic        acc_clr;
    logic        acc_en;
    logic        out_we;
    logic [11:0] out_addr;
    logic [31:0] busy_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_bus out_if ();
    ctrl_bus done_if ();

    gobou_ctrl_core dut (
        .clk          (clk),
        .xrst         (xrst),
        .req          (req),
        .in_size      (in_size),
        .out_size     (out_size),
        .net_offset   (net_offset),
        .ack          (ack),
        .mem_in_addr  (mem_in_addr),
        .mem_net_addr (mem_net_addr),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .out_ctrl     (out_if),
        .done_ctrl    (done_if),
        .out_we       (out_we),
        .out_addr     (out_addr),
        .busy_cycles  (busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the element-side outputs in one go.
    task automatic chk_elem(input string tag, input logic e_ack, input int e_in, input int e_net,
                            input logic e_clr, input logic e_en, input logic e_st,
                            input logic e_va, input logic e_sp);
        chk({tag, ".ack"},   64'(ack),            64'(e_ack));
        chk({tag, ".in"},    64'(mem_in_addr),    64'(e_in));
        chk({tag, ".net"},   64'(mem_net_addr),   64'(e_net));
        chk({tag, ".clr"},   64'(acc_clr),        64'(e_clr));
        chk({tag, ".en"},    64'(acc_en),         64'(e_en));
        chk({tag, ".start"}, 64'(out_if.start),   64'(e_st));
        chk({tag, ".valid"}, 64'(out_if.valid),   64'(e_va));
        chk({tag, ".stop"},  64'(out_if.stop),    64'(e_sp));
    endtask

    task automatic start_layer(input int n, input int m, input int off);
        req        = 1'b1;
        in_size    = 10'(n);
        out_size   = 10'(m);
        net_offset = 14'(off);
        tick();
        req        = 1'b0;
    endtask

    // Expected vectors for N=3, M=2, offset 100.
    logic [5:0] exp_clr_v   = 6'b001001; // bit k = cycle k+1
    logic [5:0] exp_valid_v = 6'b100100;

    initial begin
        xrst = 1'b0; req = 1'b0; in_size = 10'd0; out_size = 10'd0; net_offset = 14'd0;
        done_if.start = 1'b0; done_if.valid = 1'b0; done_if.stop = 1'b0;
        tick(); tick();
        chk_elem("reset", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.we",   64'(out_we),      64'd0);
        chk("reset.oadr", 64'(out_addr),    64'd0);
        chk("reset.busy", 64'(busy_cycles), 64'd0);
        xrst = 1'b1;
        tick();

        // N=3, M=2, offset 100, with a stray req and a stray stop mid-run.
        start_layer(3, 2, 100);
        for (int k = 0; k < 6; k++) begin
            chk_elem($sformatf("n3m2.c%0d", k + 1), 1'b0, k % 3, 100 + k,
                     exp_clr_v[k], 1'b1, (k == 0), exp_valid_v[k], (k == 5));
            if (k == 1) begin req = 1'b1; in_size = 10'd7; out_size = 10'd5; net_offset = 14'd9; end
            if (k == 3) begin req = 1'b0; done_if.stop = 1'b1; end
            if (k == 4) done_if.stop = 1'b0;
            tick();
        end
        chk_elem("drain", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pipeline tail returns two valids, then stop.
        done_if.valid = 1'b1; tick();
        chk("we0",    64'(out_we),   64'd1);
        chk("oadr0",  64'(out_addr), 64'd0);
        tick();
        chk("we1",    64'(out_we),   64'd1);
        chk("oadr1",  64'(out_addr), 64'd1);
        done_if.valid = 1'b0; tick();
        chk("we_off", 64'(out_we),   64'd0);
        chk("oadr2",  64'(out_addr), 64'd2);
        chk("drain.ack", 64'(ack),   64'd0);
        done_if.stop = 1'b1; tick();
        done_if.stop = 1'b0;
        chk("stop.ack", 64'(ack),    64'd1);
        tick();
        chk("idle.ack", 64'(ack),    64'd1);

        // Zero sizes are ignored.
        start_layer(0, 2, 5);
        chk_elem("zeroN", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_layer(4, 0, 5);
        chk_elem("zeroM", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // N=1, M=1: everything coincides in one cycle; out_addr cleared on accept.
        start_layer(1, 1, 7);
        chk_elem("n1m1", 1'b0, 0, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("n1m1.oadr", 64'(out_addr), 64'd0);
        tick();
        chk_elem("n1m1.drain", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        done_if.stop = 1'b1; tick(); done_if.stop = 1'b0;
        chk("n1m1.ack", 64'(ack), 64'd1);

        // Reset at element 4 of N=4, M=4.
        start_layer(4, 4, 20);
        for (int k = 0; k < 4; k++) tick();
        chk_elem("n4m4.e4", 1'b0, 0, 24, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        xrst = 1'b0; tick(); xrst = 1'b1;
        chk_elem("midrst", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.busy", 64'(busy_cycles), 64'd0);
        start_layer(2, 1, 50);
        chk_elem("rst2.c1", 1'b0, 0, 50, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_elem("rst2.c2", 1'b0, 1, 51, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        done_if.stop = 1'b1; tick(); done_if.stop = 1'b0;
        chk("rst2.ack", 64'(ack), 64'd1);

        // Busy counter: N=4, M=2, stop during the 5th drain cycle.
        start_layer(4, 2, 0);
        for (int k = 0; k < 7; k++) tick();
        chk_elem("busy.last", 1'b0, 3, 7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef GOBOU_PERF_EN
        chk("busy.mid", 64'(busy_cycles), 64'd7);
`else
        chk("busy.mid", 64'(busy_cycles), 64'd0);
`endif
        for (int k = 0; k < 5; k++) tick();
        done_if.stop = 1'b1; tick(); done_if.stop = 1'b0;
        chk("busy.ack", 64'(ack), 64'd1);
`ifdef GOBOU_PERF_EN
        chk("busy.end", 64'(busy_cycles), 64'd13);
        tick();
        chk("busy.hold", 64'(busy_cycles), 64'd13);
`else
        chk("busy.end", 64'(busy_cycles), 64'd0);
        tick();
        chk("busy.hold", 64'(busy_cycles), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
